wave_rom_arbiter: RTL and testbench
===================================

// Module: wave_rom_arbiter
// PURPOSE
//  Shares one byte-wide wave-ROM/SDRAM read port between NCH wave_sound sample players.
//  Each player raises a read strobe with a byte address; the arbiter queues it, issues the reads
//  one at a time in round-robin order, and returns the byte plus a per-channel ready flag.
//  Sits between the wave_sound channel bank and the ROM loader/SDRAM read port. Hung reads are bounded by a timeout.
// PARAMETERS
//  NCH      8    number of requesting channels (2..8)
//  AW       28   byte address width
//  TIMEOUT  255  max cycles waited in WAIT for I_ROM_ACK (1..255, 8-bit counter)
// PORTS
//  I_CLK       in   1        system clock
//  I_RSTn      in   1        asynchronous, active-low reset
//  I_FLUSH     in   1        drop all pending requests, ready flags and timeout flag
//  I_CH_RD     in   NCH      per-channel read strobe; rising edge = new request
//  I_CH_ADDR   in   NCH*AW   channel i address at [i*AW +: AW]; sampled on that channel's rising edge
//  O_CH_DATA   out  NCH*8    channel i last returned byte at [i*8 +: 8]
//  O_CH_READY  out  NCH      channel i data valid for its latest request
//  O_ROM_RD    out  1        one-cycle ROM read strobe
//  O_ROM_ADDR  out  AW       ROM byte address; held stable from ISSUE to end of WAIT
//  I_ROM_DATA  in   8        ROM read data, valid when I_ROM_ACK=1
//  I_ROM_ACK   in   1        ROM data-valid pulse; honoured only in WAIT
//  O_GRANT     out  3        index of channel currently owning the ROM port
//  O_BUSY      out  1        state != IDLE
//  O_TIMEOUT   out  1        sticky: a read timed out since last reset/flush
// BEHAVIOUR
//  Reset (async): all outputs 0; state=IDLE; pending, stale, ready and rd_q cleared; last_grant=NCH-1, so ch0 wins first.
//  Request detect: req[i] = I_CH_RD[i] & ~rd_q[i] (rd_q = I_CH_RD delayed 1 cycle).
//   On req[i]: addr[i]<=I_CH_ADDR slice; pending[i]<=1; O_CH_READY[i]<=0.
//   A level held high generates exactly one request.
//  FSM (registered state):
//   IDLE  : if any pending, grant = first pending searching (last_grant+1) mod NCH upward with wrap;
//           latch O_ROM_ADDR<=addr[grant], O_GRANT<=grant; clear timer -> ISSUE. Else stay.
//   ISSUE : O_ROM_RD=1 (Moore, exactly this one cycle) -> WAIT.
//   WAIT  : timer++ each cycle. On I_ROM_ACK: complete(I_ROM_DATA) -> IDLE.
//           On timer==TIMEOUT-1 without ack: complete(8'h00), O_TIMEOUT<=1 -> IDLE.
//  complete(d) for granted channel g:
//   - stale[g]=0: O_CH_DATA[g]<=d, O_CH_READY[g]<=1, pending[g]<=0.
//   - stale[g]=1: discard d, keep pending[g]=1 (re-issued later).
//   - Always: last_grant<=g, stale[g]<=0.
//  Same-channel re-request while g is in ISSUE/WAIT sets stale[g].
//  Re-request on the same edge as ack is also stale: the new address wins and the old data is dropped.
//  Requests from other channels during ISSUE/WAIT only set their pending bits.
//  ACK arriving in IDLE or ISSUE is ignored. The ROM side guarantees ack >= 1 cycle after O_ROM_RD.
//  Min latency: req edge k -> ISSUE after k+1 -> WAIT after k+2 -> ack at k+3 -> READY high after edge k+3.
//  Throughput: max one read per 3 cycles (IDLE, ISSUE, WAIT with immediate ack).
//  I_FLUSH (level, synchronous): pending, ready and O_TIMEOUT cleared. Any in-flight read still runs to
//   ack/timeout; its data is discarded and no ready flag is set. Requests in a flush cycle are dropped.
//  O_CH_DATA holds its value until the next non-stale completion for that channel; it is not cleared by flush.
//  Fairness: a continuously re-requesting channel cannot take two consecutive grants while others pend.
//  Async reset mid-WAIT abandons the ROM read; the ROM side tolerates an unacknowledged read.
// TESTING
//  1 reset, ch0 strobe addr 0x000002C, ROM acks 2 cycles after RD with 0x5A ->
//    RD high exactly 1 cycle, ADDR=0x2C, ch0 data=0x5A, READY[0]=1, BUSY back to 0.
//  2 ch1,ch3,ch6 strobe on the same edge, ack after 1 cycle each -> grant order 1,3,6.
//    Then ch1+ch3 again -> order 3?no: last=6 so 1 then 3. Each READY set in grant order.
//  3 ch2 re-strobes with addr 0x100 while its read of 0x0FF is in WAIT -> 0x0FF data discarded,
//    READY[2] stays 0, second ROM read at 0x100, its data delivered.
//  4 no ack, TIMEOUT=255 -> completes after 255 WAIT cycles, ch data=0x00, READY=1, O_TIMEOUT=1.
//    I_FLUSH then clears TIMEOUT.
//  5 I_CH_RD[4] held high 50 cycles -> exactly one ROM read issued.
//  6 pending on ch5 and ch7, I_FLUSH mid-WAIT for ch5 -> ch5 read finishes, no READY set,
//    ch7 never issued, BUSY 0.
//  7 async reset asserted during WAIT -> all outputs 0 immediately; next request proceeds normally.

Source files
------------

// File: rtl/wave_rom_arbiter.sv
// ---------------------------------------------------------------------------
// wave_rom_arbiter
//   Shares one byte-wide wave-ROM/SDRAM read port between NCH sample players.
//   Each channel's rising read strobe queues one request with its byte address.
//   Pending requests are served one at a time in round-robin order. Each
//   returned byte lands in that channel's data slot and sets its ready flag.
//   A read that is never acknowledged completes with 8'h00 after TIMEOUT
//   cycles and raises a sticky timeout flag.
//
// Ports
//   I_CLK, I_RSTn  clock, asynchronous active-low reset
//   I_FLUSH        drop pending requests, ready flags and the timeout flag
//   I_CH_RD        per-channel read strobe (rising edge = new request)
//   I_CH_ADDR      channel i byte address at [i*AW +: AW]
//   O_CH_DATA      channel i last returned byte at [i*8 +: 8]
//   O_CH_READY     channel i data valid for its latest request
//   O_ROM_RD       one-cycle ROM read strobe
//   O_ROM_ADDR     ROM byte address, held from ISSUE to the end of WAIT
//   I_ROM_DATA     ROM read data, valid with I_ROM_ACK
//   I_ROM_ACK      ROM data-valid pulse, only honoured in WAIT
//   O_GRANT        channel currently owning the ROM port
//   O_BUSY         arbiter not idle
//   O_TIMEOUT      sticky: a read timed out since the last reset/flush
// ---------------------------------------------------------------------------
module wave_rom_arbiter #(
    parameter int NCH     = 8,
    parameter int AW      = 28,
    parameter int TIMEOUT = 255
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic              I_FLUSH,
    input  logic [NCH-1:0]    I_CH_RD,
    input  logic [NCH*AW-1:0] I_CH_ADDR,
    output logic [NCH*8-1:0]  O_CH_DATA,
    output logic [NCH-1:0]    O_CH_READY,
    output logic              O_ROM_RD,
    output logic [AW-1:0]     O_ROM_ADDR,
    input  logic [7:0]        I_ROM_DATA,
    input  logic              I_ROM_ACK,
    output logic [2:0]        O_GRANT,
    output logic              O_BUSY,
    output logic              O_TIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  rd_q;
    logic [NCH-1:0]  req_v;
    logic [NCH-1:0]  pending_q;
    logic [NCH-1:0]  stale_q;
    logic [NCH-1:0]  own_busy;
    logic [2:0]      last_grant_q;
    logic [7:0]      timer_q;
    logic            discard_q;
    logic            discard_now;
    logic [AW-1:0]   addr_q [NCH];

    logic            next_found;
    logic [2:0]      next_grant;
    logic            grant_load;
    logic            complete;
    logic            timed_out;
    logic [7:0]      comp_data;

    // Rising-edge request detect; a flush cycle swallows any new request.
    assign req_v       = I_CH_RD & ~rd_q & {NCH{~I_FLUSH}};
    assign discard_now = discard_q | I_FLUSH;

    assign O_ROM_RD = (state_q == ST_ISSUE);
    assign O_BUSY   = (state_q != ST_IDLE);

    // Round-robin pick: lowest pending channel above last_grant, otherwise
    // the lowest pending channel overall (the wrap-around case).
    always_comb begin : p_arb
        logic       above;
        logic [2:0] first_above;
        logic [2:0] first_any;
        // NOTE: every variable driven here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        above       = 1'b0;
        first_above = '0;
        first_any   = '0;
        next_found  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                next_found = 1'b1;
                first_any  = 3'(i);
                if (3'(i) > last_grant_q) begin
                    above       = 1'b1;
                    first_above = 3'(i);
                end
            end
        end
        next_grant = above ? first_above : first_any;
    end

    // Next-state logic and completion decode.
    always_comb begin : p_fsm
        state_d    = state_q;
        grant_load = 1'b0;
        complete   = 1'b0;
        timed_out  = 1'b0;
        comp_data  = '0;
        case (state_q)
            ST_IDLE: begin
                if (next_found && !I_FLUSH) begin
                    grant_load = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (I_ROM_ACK) begin
                    complete  = 1'b1;
                    comp_data = I_ROM_DATA;
                    state_d   = ST_IDLE;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    complete  = 1'b1;
                    timed_out = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A channel "owns" the port from the grant decision until completion;
    // a new request from the owner during that window makes the read stale.
    always_comb begin
        own_busy = '0;
        for (int i = 0; i < NCH; i++) begin
            own_busy[i] = (O_BUSY && O_GRANT == 3'(i)) ||
                          (grant_load && next_grant == 3'(i));
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the per-channel address store has no reset: it is only read after
    // a request has written it, so a reset would add nothing but wiring.
    always_ff @(posedge I_CLK) begin
        for (int i = 0; i < NCH; i++) begin
            if (req_v[i]) begin
                addr_q[i] <= I_CH_ADDR[i*AW +: AW];
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            rd_q         <= '0;
            pending_q    <= '0;
            stale_q      <= '0;
            O_CH_READY   <= '0;
            O_CH_DATA    <= '0;
            O_ROM_ADDR   <= '0;
            O_GRANT      <= '0;
            O_TIMEOUT    <= 1'b0;
            last_grant_q <= 3'(NCH - 1);
            timer_q      <= '0;
            discard_q    <= 1'b0;
        end else begin
            rd_q <= I_CH_RD;

            if (grant_load) begin
                O_ROM_ADDR <= addr_q[next_grant];
                O_GRANT    <= next_grant;
                timer_q    <= '0;
                discard_q  <= 1'b0;
            end else if (state_q == ST_WAIT) begin
                timer_q <= timer_q + 8'd1;
            end

            // A flush while a read is in flight lets it finish but drops its data.
            if (I_FLUSH && O_BUSY) begin
                discard_q <= 1'b1;
            end

            if (complete) begin
                last_grant_q <= O_GRANT;
                if (timed_out) begin
                    O_TIMEOUT <= 1'b1;
                end
            end

            for (int i = 0; i < NCH; i++) begin
                if (complete && O_GRANT == 3'(i)) begin
                    // A request on the completion edge counts as stale too:
                    // the new address wins and this data is dropped.
                    if (!stale_q[i] && !req_v[i] && !discard_now) begin
                        O_CH_DATA[i*8 +: 8] <= comp_data;
                        O_CH_READY[i]       <= 1'b1;
                        pending_q[i]        <= 1'b0;
                    end
                    stale_q[i] <= 1'b0;
                end else if (req_v[i] && own_busy[i]) begin
                    stale_q[i] <= 1'b1;
                end

                if (req_v[i]) begin
                    pending_q[i]  <= 1'b1;
                    O_CH_READY[i] <= 1'b0;
                end

                if (I_FLUSH) begin
                    pending_q[i]  <= 1'b0;
                    O_CH_READY[i] <= 1'b0;
                end
            end

            if (I_FLUSH) begin
                O_TIMEOUT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wave_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wave_rom_arbiter
//   Self-checking bench for wave_rom_arbiter (NCH=8, AW=28, TIMEOUT=255).
//   A behavioural ROM answers each read after a programmable delay with a
//   byte derived from the address. Expected grant order comes from the
//   round-robin rule applied to the requested channel set. Expected data
//   comes from the same address-to-byte function the ROM uses.
// ---------------------------------------------------------------------------
module tb_wave_rom_arbiter;

    localparam int NCH = 8;
    localparam int AW  = 28;

    logic              I_CLK = 1'b0;
    logic              I_RSTn;
    logic              I_FLUSH;
    logic [NCH-1:0]    I_CH_RD;
    logic [NCH*AW-1:0] I_CH_ADDR;
    logic [NCH*8-1:0]  O_CH_DATA;
    logic [NCH-1:0]    O_CH_READY;
    logic              O_ROM_RD;
    logic [AW-1:0]     O_ROM_ADDR;
    logic [7:0]        I_ROM_DATA;
    logic              I_ROM_ACK;
    logic [2:0]        O_GRANT;
    logic              O_BUSY;
    logic              O_TIMEOUT;

    wave_rom_arbiter #(.NCH(NCH), .AW(AW), .TIMEOUT(255)) dut (
        .I_CLK      (I_CLK),
        .I_RSTn     (I_RSTn),
        .I_FLUSH    (I_FLUSH),
        .I_CH_RD    (I_CH_RD),
        .I_CH_ADDR  (I_CH_ADDR),
        .O_CH_DATA  (O_CH_DATA),
        .O_CH_READY (O_CH_READY),
        .O_ROM_RD   (O_ROM_RD),
        .O_ROM_ADDR (O_ROM_ADDR),
        .I_ROM_DATA (I_ROM_DATA),
        .I_ROM_ACK  (I_ROM_ACK),
        .O_GRANT    (O_GRANT),
        .O_BUSY     (O_BUSY),
        .O_TIMEOUT  (O_TIMEOUT)
    );

    always #5 I_CLK = ~I_CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [AW-1:0] ch_addr [NCH];
    int            model_last = NCH - 1;

    // ROM model
    int            ack_delay = 1;   // 0 = never acknowledge
    int            ack_cnt   = 0;
    int            rd_cnt    = 0;
    logic [AW-1:0] rd_addr_q [$];
    logic [2:0]    rd_grant_q [$];

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h76;
    endfunction

    initial begin
        I_ROM_ACK  = 1'b0;
        I_ROM_DATA = 8'h00;
        forever begin
            @(negedge I_CLK);
            I_ROM_ACK = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    I_ROM_ACK  = 1'b1;
                    I_ROM_DATA = rom_byte(O_ROM_ADDR);
                end
            end
            if (O_ROM_RD) begin
                rd_cnt++;
                rd_addr_q.push_back(O_ROM_ADDR);
                rd_grant_q.push_back(O_GRANT);
                ack_cnt = ack_delay;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_addr();
        for (int i = 0; i < NCH; i++) I_CH_ADDR[i*AW +: AW] = ch_addr[i];
    endtask

    // Called at a negedge; leaves the strobe high for one clock.
    task automatic strobe(input logic [NCH-1:0] mask);
        drive_addr();
        I_CH_RD = mask;
        @(negedge I_CLK);
        I_CH_RD = '0;
    endtask

    task automatic wait_ready(input string tag, input logic [NCH-1:0] mask,
                              input int budget, output int n);
        n = 0;
        while (((O_CH_READY & mask) != mask) && n < budget) begin
            @(negedge I_CLK);
            n++;
        end
        check({tag, "_ready"}, 64'((O_CH_READY & mask) == mask), 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (O_BUSY && n < budget) begin
            @(negedge I_CLK);
            n++;
        end
        check({tag, "_idle"}, 64'(O_BUSY), 64'd0);
    endtask

    task automatic wait_rd(input string tag, input int base, input int budget);
        int n;
        n = 0;
        while (rd_cnt == base && n < budget) begin
            @(negedge I_CLK);
            n++;
        end
        check({tag, "_rd_seen"}, 64'(rd_cnt != base), 64'd1);
    endtask

    // Strobe a set of channels together and check order, addresses and data.
    task automatic run_batch(input string tag, input logic [NCH-1:0] mask, output int lat);
        int base;
        int c;
        int exp_q [$];
        base = rd_cnt;
        for (int k = 1; k <= NCH; k++) begin
            c = (model_last + k) % NCH;
            if (mask[c]) exp_q.push_back(c);
        end
        strobe(mask);
        wait_ready(tag, mask, 200, lat);
        wait_idle(tag, 20);
        check({tag, "_nrd"}, 64'(rd_cnt - base), 64'(exp_q.size()));
        foreach (exp_q[j]) begin
            c = exp_q[j];
            check($sformatf("%s_grant%0d", tag, j), 64'(rd_grant_q[base + j]), 64'(c));
            check($sformatf("%s_addr%0d", tag, j), 64'(rd_addr_q[base + j]), 64'(ch_addr[c]));
            check($sformatf("%s_data_ch%0d", tag, c), 64'(O_CH_DATA[c*8 +: 8]),
                  64'(rom_byte(ch_addr[c])));
        end
        model_last = exp_q[exp_q.size() - 1];
    endtask

    initial begin
        int lat;
        int base;

        I_RSTn    = 1'b0;
        I_FLUSH   = 1'b0;
        I_CH_RD   = '0;
        I_CH_ADDR = '0;
        for (int i = 0; i < NCH; i++) ch_addr[i] = '0;
        repeat (3) @(negedge I_CLK);

        // Reset state
        check("rst_rd",      64'(O_ROM_RD),   64'd0);
        check("rst_busy",    64'(O_BUSY),     64'd0);
        check("rst_grant",   64'(O_GRANT),    64'd0);
        check("rst_ready",   64'(O_CH_READY), 64'd0);
        check("rst_timeout", 64'(O_TIMEOUT),  64'd0);
        check("rst_addr",    64'(O_ROM_ADDR), 64'd0);
        check("rst_data",    64'(O_CH_DATA),  64'd0);
        I_RSTn = 1'b1;
        @(negedge I_CLK);

        // Single read on ch0, ack two cycles after RD
        ack_delay  = 2;
        ch_addr[0] = 28'h000002C;
        base       = rd_cnt;
        strobe(8'h01);
        wait_ready("t1", 8'h01, 50, lat);
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_rd_once", 64'(rd_cnt - base), 64'd1);
        check("t1_addr",    64'(rd_addr_q[base]), 64'h2C);
        check("t1_data",    64'(O_CH_DATA[7:0]), 64'h5A);
        @(negedge I_CLK);
        check("t1_busy",    64'(O_BUSY), 64'd0);
        model_last = 0;

        // Three channels on one edge, then two more: round-robin order
        ack_delay  = 1;
        ch_addr[1] = 28'h0001111;
        ch_addr[3] = 28'h0003333;
        ch_addr[6] = 28'h0006A66;
        run_batch("t2a", 8'h4A, lat);
        ch_addr[1] = 28'h00012F1;
        ch_addr[3] = 28'h0003C03;
        run_batch("t2b", 8'h0A, lat);

        // Stale re-request during WAIT
        ack_delay  = 6;
        ch_addr[2] = 28'h00000FF;
        base       = rd_cnt;
        strobe(8'h04);
        wait_rd("t3", base, 20);
        ack_delay = 1;
        repeat (2) @(negedge I_CLK);
        ch_addr[2] = 28'h0000100;
        strobe(8'h04);
        check("t3_ready_low", 64'(O_CH_READY[2]), 64'd0);
        wait_ready("t3", 8'h04, 50, lat);
        wait_idle("t3", 20);
        check("t3_nrd",   64'(rd_cnt - base), 64'd2);
        check("t3_addr0", 64'(rd_addr_q[base]), 64'h0FF);
        check("t3_addr1", 64'(rd_addr_q[base + 1]), 64'h100);
        check("t3_data",  64'(O_CH_DATA[2*8 +: 8]), 64'h77);
        model_last = 2;

        // Timeout: no ack ever
        ack_delay  = 0;
        ch_addr[5] = 28'(($urandom & 32'h0FFF_FF00) | 32'h0000_0012);
        strobe(8'h20);
        wait_ready("t4", 8'h20, 400, lat);
        check("t4_latency", 64'(lat), 64'd257);
        check("t4_data",    64'(O_CH_DATA[5*8 +: 8]), 64'h00);
        check("t4_timeout", 64'(O_TIMEOUT), 64'd1);
        wait_idle("t4", 5);
        I_FLUSH = 1'b1;
        @(negedge I_CLK);
        I_FLUSH = 1'b0;
        check("t4_flush_timeout", 64'(O_TIMEOUT), 64'd0);
        check("t4_flush_ready",   64'(O_CH_READY), 64'd0);
        check("t4_ch0_hold",      64'(O_CH_DATA[7:0]), 64'h5A);
        model_last = 5;

        // Level held high yields exactly one read
        ack_delay  = 1;
        ch_addr[4] = 28'h0ABCDE4;
        base       = rd_cnt;
        drive_addr();
        I_CH_RD = 8'h10;
        repeat (50) @(negedge I_CLK);
        I_CH_RD = '0;
        @(negedge I_CLK);
        check("t5_nrd",   64'(rd_cnt - base), 64'd1);
        check("t5_ready", 64'(O_CH_READY[4]), 64'd1);
        check("t5_data",  64'(O_CH_DATA[4*8 +: 8]), 64'(rom_byte(28'h0ABCDE4)));
        model_last = 4;

        // Flush mid-WAIT: ch5 read runs out silently, ch7 dropped
        ack_delay  = 5;
        ch_addr[5] = 28'h0001234;
        ch_addr[7] = 28'h0007777;
        base       = rd_cnt;
        strobe(8'hA0);
        wait_rd("t6", base, 20);
        check("t6_grant", 64'(O_GRANT), 64'd5);
        @(negedge I_CLK);
        I_FLUSH = 1'b1;
        @(negedge I_CLK);
        I_FLUSH = 1'b0;
        wait_idle("t6", 30);
        repeat (10) @(negedge I_CLK);
        check("t6_nrd",     64'(rd_cnt - base), 64'd1);
        check("t6_ready",   64'(O_CH_READY), 64'd0);
        check("t6_busy",    64'(O_BUSY), 64'd0);
        check("t6_ch5hold", 64'(O_CH_DATA[5*8 +: 8]), 64'h00);
        model_last = 5;

        // Async reset in WAIT
        ack_delay  = 0;
        ch_addr[3] = 28'($urandom);
        base       = rd_cnt;
        strobe(8'h08);
        wait_rd("t7", base, 20);
        repeat (3) @(negedge I_CLK);
        I_RSTn = 1'b0;
        #1;
        check("t7_busy",  64'(O_BUSY), 64'd0);
        check("t7_rd",    64'(O_ROM_RD), 64'd0);
        check("t7_addr",  64'(O_ROM_ADDR), 64'd0);
        check("t7_grant", 64'(O_GRANT), 64'd0);
        check("t7_data",  64'(O_CH_DATA), 64'd0);
        check("t7_ready", 64'(O_CH_READY), 64'd0);
        @(negedge I_CLK);
        I_RSTn     = 1'b1;
        ack_delay  = 1;
        model_last = NCH - 1;
        @(negedge I_CLK);
        ch_addr[3] = 28'($urandom);
        run_batch("t7_after", 8'h08, lat);
        check("t7_min_latency", 64'(lat), 64'd3);

        // Randomised batches
        for (int r = 0; r < 16; r++) begin
            logic [NCH-1:0] mask;
            mask = NCH'($urandom_range(1, 255));
            for (int i = 0; i < NCH; i++) ch_addr[i] = 28'($urandom);
            ack_delay = $urandom_range(1, 4);
            run_batch($sformatf("rnd%0d", r), mask, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
